dsp19x2_accum_arbiter: RTL and testbench
========================================

DSP19X2_ACCUM_ARBITER -- requirements
Module: dsp19x2_accum_arbiter

Interface
REQ-001 Parameter: LAT, default 1, DSP pipeline latency in cycles from dsp_en to dsp_z valid (range 1-3).
REQ-002 Parameter: CNT_W, default 4, beat-counter width; maximum job length is 2^CNT_W-1 beats.
REQ-003 Port: clk, input, 1, single clock; all state changes on the rising edge.
REQ-004 Port: reset, input, 1, asynchronous, active-low; asserting it (0) clears all state immediately.
REQ-005 Port: req_valid, input, 2, per-requester beat valid.
REQ-006 Port: req_ready, output, 2, per-requester beat accept.
REQ-007 Port: req_a, input, 40, operand A per requester ({r1[19:0], r0[19:0]}).
REQ-008 Port: req_b, input, 36, operand B per requester ({r1[17:0], r0[17:0]}).
REQ-009 Port: req_last, input, 2, marks the final beat of a job.
REQ-010 Port: req_sub, input, 2, subtract mode; sampled on a job's first beat only.
REQ-011 Port: dsp_a / dsp_b, output, 20 / 18, registered operands to the DSP19x2.
REQ-012 Port: dsp_en, output, 1, the DSP consumes dsp_a/dsp_b this cycle.
REQ-013 Port: dsp_load, output, 1, first beat of a job: the accumulator loads the product instead of accumulating.
REQ-014 Port: dsp_sub, output, 1, accumulate by subtraction; held constant for the whole job.
REQ-015 Port: dsp_z, input, 38, DSP accumulator output.
REQ-016 Port: res_valid / res_ready, output / input, 1 / 1, result handshake.
REQ-017 Port: res_data, output, 38, captured dsp_z.
REQ-018 Port: res_id, output, 1, requester that owns the result.
REQ-019 Port: res_err, output, 1, the job was truncated at maximum length.

Function
REQ-020 The block SHALL implement FSM states IDLE, STREAM, DRAIN and RESULT.
REQ-021 IDLE SHALL move to STREAM when any req_valid is high, registering the granted id; the grant goes to the requester at the round-robin pointer if it is valid, else to the other requester.
REQ-022 In STREAM, req_ready SHALL be high for the granted requester only; every other req_ready bit is 0 in every other state.
REQ-023 A beat SHALL be accepted when req_valid & req_ready; on the following cycle dsp_en=1 and dsp_a/dsp_b carry that beat.
REQ-024 dsp_load SHALL be 1 only on the dsp_en cycle of a job's first beat.
REQ-025 dsp_sub SHALL latch req_sub of the first beat and hold it until the job leaves DRAIN.
REQ-026 A cycle in STREAM without an accepted beat SHALL drive dsp_en=0; dsp_a/dsp_b hold their values.
REQ-027 An accepted beat with req_last=1, or the 2^CNT_W-1th beat, SHALL move the FSM to DRAIN; truncation sets the internal error flag.
REQ-028 DRAIN SHALL last LAT cycles after the last dsp_en, then capture dsp_z into res_data, set res_valid, res_id and res_err, and enter RESULT; res_valid therefore rises LAT+1 cycles after the last-beat acceptance edge.
REQ-029 RESULT SHALL hold res_valid, res_data, res_id and res_err stable until res_ready; on the handshake it clears res_valid, toggles the pointer to the non-owner, and enters IDLE.
REQ-030 No new grant SHALL occur while in RESULT, even if res_ready and req_valid are high in the same cycle; the grant happens in IDLE on the next cycle.
REQ-031 Deassertion of the non-granted requester's req_valid SHALL have no effect on an active job.
REQ-032 The datapath SHALL be pass-through: no arithmetic on operands; widths are exactly 20/18/38 bits.

Reset
REQ-033 While reset=0: FSM=IDLE, pointer=0, and req_ready, dsp_en, dsp_load, dsp_sub, dsp_a, dsp_b, res_valid, res_data, res_id and res_err are all 0.
REQ-034 Reset mid-job or in RESULT SHALL abort the job silently; no result is produced after reset releases.

Verification
REQ-035 Reset: hold reset=0 with req_valid=2'b11 -> all outputs 0; first grant after release goes to r0.
REQ-036 Single job, LAT=1: r0 sends 3 beats (a=7, b=3), last on beat 3 -> dsp_load on beat 1 only; res_valid 2 cycles after the last-beat edge; res_id=0; res_data equals the dsp_z model.
REQ-037 Contention: both valid continuously, 2-beat jobs, res_ready=1 -> grants alternate r0, r1, r0, r1; the non-granted req_ready is always 0.
REQ-038 Backpressure: res_ready=0 for 5 cycles -> res_data stable, no grant, req_ready=0 throughout; the grant follows the cycle after the handshake.
REQ-039 Truncation, CNT_W=2: r1 sends 4 beats with no last -> job ends after beat 3 with res_err=1; beat 4 is accepted as the first beat of r1's next job (dsp_load=1).
REQ-040 Abort: reset asserted in DRAIN -> res_valid never rises; the next job starts with dsp_load=1 and pointer=0.

Source files
------------

// File: rtl/dsp19x2_accum_arbiter.sv
// Two-requester round-robin front end for a DSP19x2 multiply-accumulate slice.
// A granted requester streams operand beats into the DSP; when the job ends
// (last flag or maximum length) the block waits out the DSP pipeline, captures
// the accumulator and presents it on a valid/ready result port.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   req_valid/req_ready [1:0]  per-requester beat handshake
//   req_a [39:0], req_b [35:0] operands {r1, r0}, 20-bit A / 18-bit B
//   req_last, req_sub [1:0]    job end marker, subtract mode (first beat only)
//   dsp_a, dsp_b               registered operands to the DSP
//   dsp_en, dsp_load, dsp_sub  DSP consume / load-instead-of-accumulate / subtract
//   dsp_z [37:0]               DSP accumulator output
//   res_valid/res_ready        result handshake
//   res_data, res_id, res_err  captured accumulator, owner, truncation flag
//
// state  | meaning
// IDLE   | no job; grant on any req_valid (round-robin pointer first)
// STREAM | accepting beats from the granted requester
// DRAIN  | waiting LAT cycles for the last product to reach dsp_z
// RESULT | holding the result until res_ready

module dsp19x2_accum_arbiter #(
  parameter int LAT   = 1,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [39:0] req_a,
  input  logic [35:0] req_b,
  input  logic [1:0]  req_last,
  input  logic [1:0]  req_sub,
  output logic [19:0] dsp_a,
  output logic [17:0] dsp_b,
  output logic        dsp_en,
  output logic        dsp_load,
  output logic        dsp_sub,
  input  logic [37:0] dsp_z,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [37:0] res_data,
  output logic        res_id,
  output logic        res_err
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, RESULT} state_t;

  // Beat index (0-based) of the longest allowed job's final beat.
  localparam logic [CNT_W-1:0] CNT_TRUNC = CNT_W'((1 << CNT_W) - 2);

  state_t           state, state_nxt;
  logic             gid;
  logic             ptr;
  logic             err;
  logic [CNT_W-1:0] beat_cnt;
  logic [1:0]       drain_cnt;

  logic        sel_valid, sel_last, sel_sub;
  logic [19:0] sel_a;
  logic [17:0] sel_b;
  logic        grant_id;
  logic        beat_acc, first_beat, job_end, drain_done, res_hs;

  assign sel_valid = gid ? req_valid[1]  : req_valid[0];
  assign sel_last  = gid ? req_last[1]   : req_last[0];
  assign sel_sub   = gid ? req_sub[1]    : req_sub[0];
  assign sel_a     = gid ? req_a[39:20]  : req_a[19:0];
  assign sel_b     = gid ? req_b[35:18]  : req_b[17:0];

  assign grant_id   = req_valid[ptr] ? ptr : ~ptr;
  assign beat_acc   = (state == STREAM) && sel_valid;
  assign first_beat = (beat_cnt == '0);
  assign job_end    = beat_acc && (sel_last || (beat_cnt == CNT_TRUNC));
  assign drain_done = (state == DRAIN) && (drain_cnt == 2'd0);
  assign res_hs     = (state == RESULT) && res_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    case (state)
      IDLE:   if (|req_valid) state_nxt = STREAM;
      STREAM: begin
        req_ready = gid ? 2'b10 : 2'b01;
        if (job_end) state_nxt = DRAIN;
      end
      DRAIN:  if (drain_done) state_nxt = RESULT;
      RESULT: if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gid       <= 1'b0;
      ptr       <= 1'b0;
      err       <= 1'b0;
      beat_cnt  <= '0;
      drain_cnt <= 2'd0;
      dsp_a     <= '0;
      dsp_b     <= '0;
      dsp_en    <= 1'b0;
      dsp_load  <= 1'b0;
      dsp_sub   <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= 1'b0;
      res_err   <= 1'b0;
    end else begin
      dsp_en   <= beat_acc;
      dsp_load <= beat_acc && first_beat;

      if (state == IDLE && |req_valid) begin
        gid      <= grant_id;
        beat_cnt <= '0;
        err      <= 1'b0;
      end

      if (beat_acc) begin
        dsp_a    <= sel_a;
        dsp_b    <= sel_b;
        beat_cnt <= beat_cnt + 1'b1;
        if (first_beat) dsp_sub <= sel_sub;
      end

      // Reaching the length limit without a last flag is a truncation.
      if (job_end) begin
        drain_cnt <= 2'(LAT);
        err       <= ~sel_last;
      end

      if ((state == DRAIN) && !drain_done) drain_cnt <= drain_cnt - 1'b1;

      if (drain_done) begin
        res_valid <= 1'b1;
        res_data  <= dsp_z;
        res_id    <= gid;
        res_err   <= err;
        dsp_sub   <= 1'b0;
      end

      if (res_hs) begin
        res_valid <= 1'b0;
        ptr       <= ~res_id;
      end
    end
  end

endmodule

// File: tb/tb_dsp19x2_accum_arbiter.sv
// Directed bench for dsp19x2_accum_arbiter with a behavioural DSP19x2
// accumulator on dsp_z and a scoreboard of expected job results.
module tb_dsp19x2_accum_arbiter;
  localparam int LAT    = 1;
  localparam int CNT_W  = 2;
  localparam int BUDGET = 40;

  logic        clk, reset;
  logic [1:0]  req_valid, req_ready, req_last, req_sub;
  logic [39:0] req_a;
  logic [35:0] req_b;
  logic [19:0] dsp_a;
  logic [17:0] dsp_b;
  logic        dsp_en, dsp_load, dsp_sub;
  logic [37:0] dsp_z;
  logic        res_valid, res_ready, res_id, res_err;
  logic [37:0] res_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = 0;

  typedef struct packed {
    logic        id;
    logic        err;
    logic [37:0] data;
  } exp_t;
  exp_t sbq[$];
  exp_t dropped;

  dsp19x2_accum_arbiter #(.LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_last(req_last), .req_sub(req_sub),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_en(dsp_en), .dsp_load(dsp_load),
    .dsp_sub(dsp_sub), .dsp_z(dsp_z),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .res_err(res_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // External DSP: signed multiply, single pipeline stage (LAT = 1).
  logic signed [37:0] z_q = '0;
  logic signed [37:0] dax, dbx, dprod;
  assign dax   = {{18{dsp_a[19]}}, dsp_a};
  assign dbx   = {{20{dsp_b[17]}}, dsp_b};
  assign dprod = dax * dbx;
  always_ff @(posedge clk) begin
    if (dsp_en) begin
      if (dsp_load) z_q <= dsp_sub ? -dprod : dprod;
      else          z_q <= dsp_sub ? z_q - dprod : z_q + dprod;
    end
  end
  assign dsp_z = z_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive_beat(input bit id, input logic [19:0] a, input logic [17:0] b,
                            input bit last, input bit sub);
    req_valid[id] = 1'b1;
    if (id) begin
      req_a[39:20] = a;
      req_b[35:18] = b;
    end else begin
      req_a[19:0] = a;
      req_b[17:0] = b;
    end
    req_last[id] = last;
    req_sub[id]  = sub;
  endtask

  // Streams n beats (a = a0 + i*ainc, constant b); req_sub toggles after the
  // first beat to show only the first beat's value matters.
  task automatic send_job(input bit id, input int n, input bit last,
                          input logic [19:0] a0, input logic [19:0] ainc,
                          input logic [17:0] b, input bit sub, input bit gap,
                          input bit exp_err);
    logic signed [37:0] acc, p, ax_m, bx_m;
    logic [19:0] ai;
    int waited;
    exp_t e;
    acc = '0;
    for (int i = 0; i < n; i++) begin
      ai = a0 + 20'(i) * ainc;
      drive_beat(id, ai, b, last && (i == n - 1), (i == 0) ? sub : !sub);
      waited = 0;
      while (!req_ready[id] && waited < BUDGET) begin
        chk("ready_other_wait", req_ready[!id], 1'b0);
        @(negedge clk);
        waited++;
      end
      if (!req_ready[id]) begin
        chk("grant_timeout", req_ready[id], 1'b1);
        req_valid[id] = 1'b0;
        return;
      end
      @(negedge clk);
      chk("dsp_en", dsp_en, 1'b1);
      chk("dsp_a", dsp_a, ai);
      chk("dsp_b", dsp_b, b);
      chk("dsp_load", dsp_load, i == 0);
      chk("dsp_sub", dsp_sub, sub);
      chk("ready_other", req_ready[!id], 1'b0);
      ax_m = {{18{ai[19]}}, ai};
      bx_m = {{20{b[17]}}, b};
      p = ax_m * bx_m;
      if (i == 0) acc = sub ? -p : p;
      else        acc = sub ? acc - p : acc + p;
      if (gap && i == 0 && n > 1) begin
        req_valid[id] = 1'b0;
        @(negedge clk);
        chk("gap_dsp_en", dsp_en, 1'b0);
        chk("gap_dsp_a_hold", dsp_a, ai);
      end
    end
    req_valid[id] = 1'b0;
    last_cyc = cyc;
    e.id   = id;
    e.err  = exp_err;
    e.data = acc;
    sbq.push_back(e);
  endtask

  // Waits for res_valid, compares against the scoreboard, optionally holds
  // res_ready low for `hold` cycles; returns just before the handshake edge.
  task automatic wait_result(input int hold);
    exp_t e;
    int waited;
    waited = 0;
    if (hold > 0) res_ready = 1'b0;
    while (!res_valid && waited < BUDGET) begin
      chk("drain_ready", req_ready, 2'b00);
      @(negedge clk);
      waited++;
    end
    if (!res_valid) begin
      chk("res_timeout", res_valid, 1'b1);
      res_ready = 1'b1;
      return;
    end
    chk("res_latency", cyc - last_cyc, LAT + 1);
    if (sbq.size() == 0) begin
      chk("res_unexpected", res_valid, 1'b0);
      res_ready = 1'b1;
      return;
    end
    e = sbq.pop_front();
    chk("res_data", res_data, e.data);
    chk("res_id", res_id, e.id);
    chk("res_err", res_err, e.err);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("bp_valid", res_valid, 1'b1);
      chk("bp_data", res_data, e.data);
      chk("bp_ready", req_ready, 2'b00);
    end
    res_ready = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_last  = '0;
    req_sub   = '0;
    res_ready = 1'b1;
    #1 reset = 1'b0;

    // Reset with both requesters asking.
    drive_beat(1'b0, 20'd5, 18'd2, 1'b1, 1'b0);
    drive_beat(1'b1, 20'd9, 18'd9, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_dsp_ctl", {dsp_en, dsp_load, dsp_sub}, 3'b000);
    chk("rst_dsp_ops", {dsp_a, dsp_b}, 38'd0);
    chk("rst_res_ctl", {res_valid, res_id, res_err}, 3'b000);
    chk("rst_res_data", res_data, 38'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("first_grant_r0", req_ready, 2'b01);
    req_valid[1] = 1'b0;
    send_job(1'b0, 1, 1'b1, 20'd5, 20'd0, 18'd2, 1'b0, 1'b0, 1'b0);
    wait_result(0);

    // Single three-beat job from r0.
    send_job(1'b0, 3, 1'b1, 20'd7, 20'd0, 18'd3, 1'b0, 1'b0, 1'b0);
    wait_result(0);

    // Truncation: r1 sends four beats with no last; fourth starts a new job.
    send_job(1'b1, 3, 1'b0, 20'h00100, 20'h00010, 18'h3FFFE, 1'b1, 1'b1, 1'b1);
    drive_beat(1'b1, 20'h00130, 18'h3FFFE, 1'b1, 1'b0);
    wait_result(0);
    send_job(1'b1, 1, 1'b1, 20'h00130, 20'd0, 18'h3FFFE, 1'b0, 1'b0, 1'b0);
    wait_result(0);

    // Contention: both requesters keep a beat pending, grants alternate.
    drive_beat(1'b1, 20'd11, 18'd4, 1'b0, 1'b0);
    send_job(1'b0, 2, 1'b1, 20'hFFFFD, 20'd1, 18'd5, 1'b0, 1'b0, 1'b0);
    drive_beat(1'b0, 20'd2, 18'd6, 1'b0, 1'b1);
    wait_result(0);
    send_job(1'b1, 2, 1'b1, 20'd11, 20'd1, 18'd4, 1'b0, 1'b0, 1'b0);
    drive_beat(1'b1, 20'd20, 18'h3FFFF, 1'b0, 1'b0);
    wait_result(0);
    send_job(1'b0, 2, 1'b1, 20'd2, 20'd3, 18'd6, 1'b1, 1'b0, 1'b0);
    wait_result(0);
    send_job(1'b1, 2, 1'b1, 20'd20, 20'd1, 18'h3FFFF, 1'b0, 1'b0, 1'b0);
    wait_result(0);

    // Backpressure: r0 waits through a stalled result.
    send_job(1'b1, 2, 1'b1, 20'd100, 20'd5, 18'd7, 1'b0, 1'b0, 1'b0);
    drive_beat(1'b0, 20'd42, 18'd2, 1'b1, 1'b0);
    wait_result(5);
    @(negedge clk);
    chk("hs_valid_clr", res_valid, 1'b0);
    chk("hs_no_grant", req_ready, 2'b00);
    @(negedge clk);
    chk("post_hs_grant", req_ready, 2'b01);
    send_job(1'b0, 1, 1'b1, 20'd42, 20'd0, 18'd2, 1'b0, 1'b0, 1'b0);
    wait_result(0);

    // Abort: reset during DRAIN of an r1 job (pointer is at r1 beforehand).
    send_job(1'b1, 1, 1'b1, 20'd8, 20'd0, 18'd8, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    dropped = sbq.pop_back();
    drive_beat(1'b0, 20'd3, 18'd3, 1'b1, 1'b0);
    drive_beat(1'b1, 20'd4, 18'd4, 1'b1, 1'b0);
    @(negedge clk);
    chk("abort_res_valid", res_valid, 1'b0);
    chk("abort_dsp_en", dsp_en, 1'b0);
    chk("abort_ready", req_ready, 2'b00);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_res_valid2", res_valid, 1'b0);
    chk("abort_ptr0_grant", req_ready, 2'b01);
    req_valid[1] = 1'b0;
    send_job(1'b0, 1, 1'b1, 20'd3, 20'd0, 18'd3, 1'b0, 1'b0, 1'b0);
    wait_result(0);
    @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    chk("final_res_valid", res_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
